// File: rtl/wta_layer_scheduler.sv
// Winner-take-all scheduler: time-multiplexes one threshold neuron
// over NUM_NEURONS rows, reports the lowest-index winner, then inhibits.
module wta_layer_scheduler #(
    parameter int unsigned NUM_SPIKES     = 8,
    parameter int unsigned NUM_NEURONS    = 16,
    parameter int unsigned AW             = $clog2(NUM_NEURONS),
    parameter int unsigned INHIBIT_CYCLES = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_SPIKES-1:0] in_spikes,
    output logic [NUM_SPIKES-1:0] nrn_spikes,
    output logic                  w_en,
    output logic [AW-1:0]         w_addr,
    input  logic                  nrn_fire,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_fired,
    output logic [AW-1:0]         out_winner,
    output logic                  busy,
    output logic [CNT_W-1:0]      fire_count
);

    localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [AW-1:0] LAST = AW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, INHIBIT} state_t;

    state_t                  state_q;
    logic [NUM_SPIKES-1:0]   spk_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    w_en_q;
    logic [AW-1:0]           w_addr_q;
    logic                    pend_q;
    logic [AW-1:0]           samp_q;
    logic                    out_valid_q;
    logic                    out_fired_q;
    logic [AW-1:0]           out_winner_q;
    logic [IW-1:0]           cnt_q;
    logic [CNT_W-1:0]        fire_count_q;

    assign in_ready   = in_ready_q;
    assign nrn_spikes = spk_q;
    assign w_en       = w_en_q;
    assign w_addr     = w_addr_q;
    assign out_valid  = out_valid_q;
    assign out_fired  = out_fired_q;
    assign out_winner = out_winner_q;
    assign busy       = busy_q;
    assign fire_count = fire_count_q;

    // Control FSM; w_addr_q is the address being read this cycle, samp_q the
    // address whose fire bit arrives this cycle (one-cycle memory latency).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spk_q        <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            pend_q       <= 1'b0;
            samp_q       <= '0;
            out_valid_q  <= 1'b0;
            out_fired_q  <= 1'b0;
            out_winner_q <= '0;
            cnt_q        <= '0;
            fire_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        spk_q      <= in_spikes;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        w_en_q     <= 1'b1;
                        w_addr_q   <= '0;
                        pend_q     <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    pend_q <= w_en_q;
                    samp_q <= w_addr_q;
                    if (w_en_q && (w_addr_q != LAST)) begin
                        w_addr_q <= w_addr_q + 1'b1;
                    end else begin
                        w_en_q   <= 1'b0;
                        w_addr_q <= '0;
                    end
                    if (pend_q && nrn_fire) begin
                        w_en_q       <= 1'b0;
                        w_addr_q     <= '0;
                        pend_q       <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_fired_q  <= 1'b1;
                        out_winner_q <= samp_q;
                        state_q      <= REPORT;
                    end else if (pend_q && (samp_q == LAST)) begin
                        pend_q       <= 1'b0;
                        out_valid_q  <= 1'b1;
                        out_fired_q  <= 1'b0;
                        out_winner_q <= '0;
                        state_q      <= REPORT;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        out_fired_q  <= 1'b0;
                        out_winner_q <= '0;
                        if (out_fired_q && (fire_count_q != '1)) begin
                            fire_count_q <= fire_count_q + 1'b1;
                        end
                        if (out_fired_q && (INHIBIT_CYCLES > 0)) begin
                            cnt_q   <= IW'(INHIBIT_CYCLES - 1);
                            state_q <= INHIBIT;
                        end else begin
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                INHIBIT: begin
                    if (cnt_q == '0) begin
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wta_layer_scheduler.sv
// Self-checking bench for wta_layer_scheduler: table-driven volleys with a
// result scoreboard, plus reset, backpressure and saturation sequences.
module tb_wta_layer_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid_a, in_ready_a, w_en_a, nrn_fire_a;
    logic        out_valid_a, out_ready_a, out_fired_a, busy_a;
    logic [7:0]  in_spikes_a, nrn_spikes_a;
    logic [3:0]  w_addr_a, out_winner_a;
    logic [15:0] fire_count_a;

    logic        in_valid_b, in_ready_b, w_en_b, nrn_fire_b;
    logic        out_valid_b, out_ready_b, out_fired_b, busy_b;
    logic [7:0]  in_spikes_b, nrn_spikes_b;
    logic [3:0]  w_addr_b, out_winner_b;
    logic [1:0]  fire_count_b;

    logic [15:0] mask;
    logic [15:0] rd_log;
    logic        clr_log;

    wta_layer_scheduler dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_spikes(in_spikes_a), .nrn_spikes(nrn_spikes_a),
        .w_en(w_en_a), .w_addr(w_addr_a), .nrn_fire(nrn_fire_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_fired(out_fired_a), .out_winner(out_winner_a),
        .busy(busy_a), .fire_count(fire_count_a)
    );

    wta_layer_scheduler #(.INHIBIT_CYCLES(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_spikes(in_spikes_b), .nrn_spikes(nrn_spikes_b),
        .w_en(w_en_b), .w_addr(w_addr_b), .nrn_fire(nrn_fire_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_fired(out_fired_b), .out_winner(out_winner_b),
        .busy(busy_b), .fire_count(fire_count_b)
    );

    // Weight memory + neuron model: fire bit one cycle after the read.
    always @(posedge clk) begin
        nrn_fire_a <= w_en_a && mask[w_addr_a];
        nrn_fire_b <= w_en_b && mask[w_addr_b];
        if (clr_log) rd_log <= '0;
        else if (w_en_a) rd_log[w_addr_a] <= 1'b1;
    end

    typedef struct {
        logic [7:0]  spk;
        logic [15:0] mask;
        int          stall;
        logic        exp_fired;
        logic [3:0]  exp_winner;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic       f;
        logic [3:0] w;
    } res_t;

    vec_t vecs[6];
    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_model = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_a(input vec_t v);
        int c;
        int hi;
        res_t e;
        logic [31:0] exp_rd;
        mask = v.mask;
        c = 0;
        while (!in_ready_a && c < 50) begin @(negedge clk); c++; end
        chk("ready_wait", {31'd0, in_ready_a}, 32'd1);
        in_spikes_a = v.spk;
        in_valid_a  = 1'b1;
        clr_log     = 1'b1;
        @(posedge clk);
        sb.push_back('{v.exp_fired, v.exp_winner});
        @(negedge clk);
        in_valid_a  = 1'b0;
        clr_log     = 1'b0;
        in_spikes_a = ~v.spk;
        c = 1;
        chk("busy", {31'd0, busy_a}, 32'd1);
        while (!out_valid_a && c < 40) begin @(negedge clk); c++; end
        chk("latency", c, v.exp_lat);
        chk("spikes", {24'd0, nrn_spikes_a}, {24'd0, v.spk});
        for (int i = 0; i < v.stall; i++) begin
            in_valid_a  = 1'b1;
            in_spikes_a = 8'h00;
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid_a}, 32'd1);
            chk("stall_winner", {28'd0, out_winner_a}, {28'd0, v.exp_winner});
            chk("stall_ready", {31'd0, in_ready_a}, 32'd0);
            chk("stall_spikes", {24'd0, nrn_spikes_a}, {24'd0, v.spk});
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("fired", {31'd0, out_fired_a}, {31'd0, e.f});
            chk("winner", {28'd0, out_winner_a}, {28'd0, e.w});
        end else begin
            errors++;
            $display("FAIL scoreboard_empty actual 0 required 1");
        end
        @(posedge clk);
        if (v.exp_fired) cnt_model++;
        @(negedge clk);
        out_ready_a = 1'b0;
        chk("valid_drop", {31'd0, out_valid_a}, 32'd0);
        chk("fire_count", {16'd0, fire_count_a}, cnt_model);
        hi = v.exp_fired ? ((v.exp_winner == 4'd15) ? 15 : v.exp_winner + 1) : 15;
        exp_rd = (32'd1 << (hi + 1)) - 32'd1;
        chk("reads", {16'd0, rd_log}, {16'd0, exp_rd[15:0]});
        c = 0;
        while (!in_ready_a && c < 20) begin @(negedge clk); c++; end
        chk("lockout", c, v.exp_fired ? 4 : 0);
    endtask

    task automatic run_b(input logic [1:0] exp_cnt);
        int c;
        mask = 16'h0002;
        in_spikes_b = 8'h33;
        in_valid_b  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_b = 1'b0;
        c = 1;
        while (!out_valid_b && c < 40) begin @(negedge clk); c++; end
        chk("b_latency", c, 4);
        chk("b_winner", {28'd0, out_winner_b}, 32'd1);
        out_ready_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_b = 1'b0;
        chk("b_ready_after", {31'd0, in_ready_b}, 32'd1);
        chk("b_fire_count", {30'd0, fire_count_b}, {30'd0, exp_cnt});
    endtask

    initial begin
        int c;
        logic [1:0] exp_b [5];
        vecs[0] = '{8'hFF, 16'h0020, 0,  1'b1, 4'd5,  8};
        vecs[1] = '{8'hA5, 16'h0208, 0,  1'b1, 4'd3,  6};
        vecs[2] = '{8'h3C, 16'h0000, 0,  1'b0, 4'd0,  18};
        vecs[3] = '{8'h5A, 16'h0001, 10, 1'b1, 4'd0,  3};
        vecs[4] = '{8'h81, 16'h8000, 0,  1'b1, 4'd15, 18};
        vecs[5] = '{8'h42, 16'h0084, 0,  1'b1, 4'd2,  5};
        exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        mask = '0;
        clr_log = 1'b1;
        in_valid_a = 1'b0; out_ready_a = 1'b0; in_spikes_a = '0;
        in_valid_b = 1'b0; out_ready_b = 1'b0; in_spikes_b = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr_log = 1'b0;

        chk("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_w_en", {31'd0, w_en_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_fire_count", {16'd0, fire_count_a}, 32'd0);
        chk("rst_spikes", {24'd0, nrn_spikes_a}, 32'd0);

        for (int i = 0; i < 5; i++) run_a(vecs[i]);

        mask = 16'h0000;
        in_spikes_a = 8'h77;
        in_valid_a  = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        c = 0;
        while (!(w_en_a && w_addr_a == 4'd7) && c < 30) begin
            @(negedge clk); c++;
        end
        chk("reach_addr7", {28'd0, w_addr_a}, 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_model = 0;
        chk("mid_rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        chk("mid_rst_w_en", {31'd0, w_en_a}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("mid_rst_fire_count", {16'd0, fire_count_a}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        run_a(vecs[5]);

        for (int i = 0; i < 5; i++) run_b(exp_b[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
